// File: rtl/rmt_ingress_arb.sv
// Frame-level round-robin merge of PORT_COUNT AXI-Stream ingress ports onto one tagged output stream.
// Latency: grant one cycle after eligible valid, output beat one cycle after ingress acceptance.
// Backpressure: granted port's tready follows the single output register (full throughput); others held at 0.
module rmt_ingress_arb #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int USER_WIDTH = 8,
    parameter int PORT_COUNT = 4,
    parameter int DEST_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORT_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [PORT_COUNT-1:0]            s_axis_tvalid,
    output logic [PORT_COUNT-1:0]            s_axis_tready,
    input  logic [PORT_COUNT-1:0]            s_axis_tlast,
    input  logic [PORT_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic [DEST_WIDTH-1:0]            m_axis_tdest,
    input  logic [PORT_COUNT-1:0]            port_enable,
    output logic [PORT_COUNT-1:0]            grant,
    output logic                             busy
);

    typedef enum logic {
        ST_IDLE,
        ST_TRANSFER
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PORT_COUNT-1:0]   r_grant;
    logic [DEST_WIDTH-1:0]   r_tdest;
    logic [DEST_WIDTH-1:0]   r_rr_ptr;

    logic                    r_m_vld;
    logic                    r_m_last;
    logic [DATA_WIDTH-1:0]   r_m_dat;
    logic [KEEP_WIDTH-1:0]   r_m_keep;
    logic [USER_WIDTH-1:0]   r_m_user;
    logic [DEST_WIDTH-1:0]   r_m_dest;

    logic [PORT_COUNT-1:0]   w_elig;
    logic [PORT_COUNT-1:0]   w_elig_rot;
    logic [DEST_WIDTH-1:0]   w_sel_off;
    logic [DEST_WIDTH:0]     w_sel_sum;
    logic [DEST_WIDTH-1:0]   w_sel_idx;
    logic [PORT_COUNT-1:0]   w_sel_onehot;

    logic                    w_g_vld;
    logic                    w_g_last;
    logic [DATA_WIDTH-1:0]   w_g_dat;
    logic [KEEP_WIDTH-1:0]   w_g_keep;
    logic [USER_WIDTH-1:0]   w_g_user;

    logic                    w_fwd_ok;
    logic                    w_accept;
    logic                    w_start;
    logic                    w_end;

    assign w_elig = s_axis_tvalid & port_enable;

    // Rotate so bit 0 is rr_ptr; the lowest set bit of the rotated vector is the winner.
    assign w_elig_rot = PORT_COUNT'({w_elig, w_elig} >> r_rr_ptr);

    always_comb begin
        w_sel_off = '0;
        for (int k = PORT_COUNT - 1; k >= 0; k--) begin
            if (w_elig_rot[k]) begin
                w_sel_off = DEST_WIDTH'(k);
            end
        end
        w_sel_sum = {1'b0, r_rr_ptr} + {1'b0, w_sel_off};
        if (w_sel_sum >= (DEST_WIDTH + 1)'(PORT_COUNT)) begin
            w_sel_sum = w_sel_sum - (DEST_WIDTH + 1)'(PORT_COUNT);
        end
        w_sel_idx    = w_sel_sum[DEST_WIDTH-1:0];
        w_sel_onehot = PORT_COUNT'(1) << w_sel_idx;
    end

    always_comb begin
        w_g_vld  = 1'b0;
        w_g_last = 1'b0;
        w_g_dat  = '0;
        w_g_keep = '0;
        w_g_user = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (r_grant[i]) begin
                w_g_vld  = s_axis_tvalid[i];
                w_g_last = s_axis_tlast[i];
                w_g_dat  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_g_keep = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                w_g_user = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    assign w_fwd_ok      = !r_m_vld || m_axis_tready;
    assign w_accept      = (r_state == ST_TRANSFER) && w_g_vld && w_fwd_ok;
    assign s_axis_tready = ((r_state == ST_TRANSFER) && w_fwd_ok) ? r_grant : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_state_nxt = ST_TRANSFER;
                    w_start     = 1'b1;
                end
            end
            ST_TRANSFER: begin
                if (w_accept && w_g_last) begin
                    w_state_nxt = ST_IDLE;
                    w_end       = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant  <= '0;
            r_tdest  <= '0;
            r_rr_ptr <= '0;
        end else if (w_start) begin
            r_grant <= w_sel_onehot;
            r_tdest <= w_sel_idx;
        end else if (w_end) begin
            r_grant  <= '0;
            r_rr_ptr <= (r_tdest == DEST_WIDTH'(PORT_COUNT - 1)) ? '0 : r_tdest + DEST_WIDTH'(1);
        end
    end

    // The output register drains on its own, so a held last beat can outlive the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_vld  <= 1'b0;
            r_m_last <= 1'b0;
            r_m_dat  <= '0;
            r_m_keep <= '0;
            r_m_user <= '0;
            r_m_dest <= '0;
        end else if (w_accept) begin
            r_m_vld  <= 1'b1;
            r_m_last <= w_g_last;
            r_m_dat  <= w_g_dat;
            r_m_keep <= w_g_keep;
            r_m_user <= w_g_user;
            r_m_dest <= r_tdest;
        end else if (m_axis_tready) begin
            r_m_vld <= 1'b0;
        end
    end

    assign m_axis_tvalid = r_m_vld;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_tdata  = r_m_dat;
    assign m_axis_tkeep  = r_m_keep;
    assign m_axis_tuser  = r_m_user;
    assign m_axis_tdest  = r_m_dest;
    assign grant         = r_grant;
    assign busy          = (r_state == ST_TRANSFER);

endmodule

// File: tb/tb_rmt_ingress_arb.sv
// Randomized bench for rmt_ingress_arb: frame queues per port, a queue-based reference model
// compared every cycle, plus directed scenarios with hand-computed cycle/order expectations.
module tb_rmt_ingress_arb;
    localparam int DW = 512;
    localparam int KW = 64;
    localparam int UW = 8;
    localparam int P  = 4;
    localparam int DSTW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [P*DW-1:0] s_tdata;
    logic [P*KW-1:0] s_tkeep;
    logic [P-1:0]    s_tvalid;
    logic [P-1:0]    s_tready;
    logic [P-1:0]    s_tlast;
    logic [P*UW-1:0] s_tuser;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [UW-1:0]   m_tuser;
    logic [DSTW-1:0] m_tdest;
    logic [P-1:0]    port_en;
    logic [P-1:0]    grant;
    logic            busy;

    rmt_ingress_arb #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .PORT_COUNT(P), .DEST_WIDTH(DSTW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .m_axis_tdest(m_tdest), .port_enable(port_en), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          last;
        logic [UW-1:0] u;
        int            dst;
    } beat_t;

    typedef struct {
        int            cyc;
        int            dst;
        logic [DW-1:0] d;
        logic          last;
    } obs_t;

    beat_t    q[P][$];
    beat_t    pend[$];
    obs_t     olog[$];
    bit       busy_hist[int];
    bit [P-1:0] vld_r;
    logic [P-1:0] en;
    int       vld_pct;
    int       rdy_pct;
    bit       mb;
    int       mg;
    int       mrr;
    int       cyc;
    int       n_chk;
    int       n_pass;
    logic [P-1:0] o_grant;
    logic [P-1:0] o_rdy;

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic add_frame(int p, int len, bit incr);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.d = '0;
            if (incr) x.d[31:0] = b;
            else for (int w = 0; w < DW / 32; w++) x.d[w*32 +: 32] = $urandom();
            x.k    = {$urandom(), $urandom()};
            x.u    = 8'($urandom());
            x.last = (b == len - 1);
            x.dst  = p;
            q[p].push_back(x);
        end
    endtask

    function automatic bit model_idle();
        bit r = !mb && (pend.size() == 0);
        for (int i = 0; i < P; i++) if (q[i].size() != 0) r = 0;
        return r;
    endfunction

    // One clock cycle: drive at negedge, compare at negedge+1, advance model at posedge.
    task automatic step();
        logic [P-1:0] oh;
        logic [P-1:0] xr;
        logic [P-1:0] elig;
        beat_t        b;
        obs_t         o;
        for (int i = 0; i < P; i++) begin
            if (!vld_r[i] && q[i].size() > 0 && $urandom_range(0, 99) < vld_pct) vld_r[i] = 1'b1;
            if (q[i].size() > 0) begin
                s_tdata[i*DW +: DW] = q[i][0].d;
                s_tkeep[i*KW +: KW] = q[i][0].k;
                s_tuser[i*UW +: UW] = q[i][0].u;
                s_tlast[i]          = q[i][0].last;
            end else begin
                s_tdata[i*DW +: DW] = '0;
                s_tkeep[i*KW +: KW] = '0;
                s_tuser[i*UW +: UW] = '0;
                s_tlast[i]          = 1'b0;
            end
        end
        s_tvalid = vld_r;
        port_en  = en;
        m_tready = ($urandom_range(0, 99) < rdy_pct);
        #1;
        oh = '0;
        if (mb) oh[mg] = 1'b1;
        xr = (mb && (pend.size() == 0 || m_tready)) ? oh : '0;
        o_grant = grant;
        o_rdy   = s_tready;
        chk("grant", grant, oh);
        chk("busy", busy, mb);
        chk("s_tready", s_tready, xr);
        chk("m_tvalid", m_tvalid, pend.size() != 0);
        if (pend.size() != 0) begin
            chk("m_tdata", m_tdata, pend[0].d);
            chk("m_tkeep", m_tkeep, pend[0].k);
            chk("m_tlast", m_tlast, pend[0].last);
            chk("m_tuser", m_tuser, pend[0].u);
            chk("m_tdest", m_tdest, pend[0].dst);
        end
        busy_hist[cyc] = busy;
        if (m_tvalid && m_tready) begin
            o.cyc = cyc; o.dst = int'(m_tdest); o.d = m_tdata; o.last = m_tlast;
            olog.push_back(o);
        end
        @(posedge clk);
        if (m_tready && pend.size() > 0) void'(pend.pop_front());
        if (mb) begin
            if (vld_r[mg] && xr[mg]) begin
                b = q[mg].pop_front();
                pend.push_back(b);
                vld_r[mg] = 1'b0;
                if (b.last) begin
                    mb  = 1'b0;
                    mrr = (mg + 1) % P;
                end
            end
        end else begin
            elig = vld_r & en;
            if (elig != 0) begin
                for (int k = P - 1; k >= 0; k--) if (elig[(mrr + k) % P]) mg = (mrr + k) % P;
                mb = 1'b1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(bit check);
        rst_n = 1'b0;
        #1;
        if (check) begin
            chk("rst_grant", grant, 0);
            chk("rst_busy", busy, 0);
            chk("rst_s_tready", s_tready, 0);
            chk("rst_m_tvalid", m_tvalid, 0);
            chk("rst_m_tlast", m_tlast, 0);
            chk("rst_m_tdata", m_tdata, 0);
            chk("rst_m_tkeep", m_tkeep, 0);
            chk("rst_m_tuser", m_tuser, 0);
            chk("rst_m_tdest", m_tdest, 0);
        end
        mb = 1'b0; mrr = 0; mg = 0;
        pend.delete();
        for (int i = 0; i < P; i++) q[i].delete();
        vld_r = '0;
        s_tvalid = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(int bound);
        int k = 0;
        while (k < bound && !model_idle()) begin
            step();
            k++;
        end
        chk("drain_done", model_idle(), 1);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n0;
        int l0;
        int ec[6];
        int ed[6];
        int p;
        n_chk = 0; n_pass = 0; cyc = 0;
        mb = 0; mg = 0; mrr = 0; vld_r = '0;
        en = '1; vld_pct = 100; rdy_pct = 100;
        s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
        m_tready = 1'b0; port_en = '1;
        @(negedge clk);
        do_reset(1);

        // Single 3-beat frame on port 0
        n0 = cyc; l0 = olog.size();
        add_frame(0, 3, 0);
        drain(50);
        chk("t1_beats", olog.size() - l0, 3);
        for (int b = 0; b < 3 && l0 + b < olog.size(); b++) begin
            chk("t1_cycle", olog[l0+b].cyc, n0 + 2 + b);
            chk("t1_dest", olog[l0+b].dst, 0);
            chk("t1_last", olog[l0+b].last, b == 2);
        end
        chk("t1_busy_mid", busy_hist[n0+3], 1);
        chk("t1_busy_after", busy_hist[n0+4], 0);

        // Three ports, 2-beat frames, round-robin from 0 with one idle cycle between frames
        do_reset(0);
        n0 = cyc; l0 = olog.size();
        add_frame(0, 2, 0); add_frame(1, 2, 0); add_frame(2, 2, 0);
        drain(100);
        ec = '{2, 3, 5, 6, 8, 9};
        ed = '{0, 0, 1, 1, 2, 2};
        chk("t2_beats", olog.size() - l0, 6);
        for (int b = 0; b < 6 && l0 + b < olog.size(); b++) begin
            chk("t2_cycle", olog[l0+b].cyc, n0 + ec[b]);
            chk("t2_dest", olog[l0+b].dst, ed[b]);
        end

        // After port 3, eligible {1,3} wraps to port 1 first
        do_reset(0);
        add_frame(3, 2, 0);
        drain(50);
        l0 = olog.size();
        add_frame(1, 2, 0); add_frame(3, 2, 0);
        drain(100);
        ed = '{1, 1, 3, 3, 0, 0};
        chk("t3_beats", olog.size() - l0, 4);
        for (int b = 0; b < 4 && l0 + b < olog.size(); b++) chk("t3_dest", olog[l0+b].dst, ed[b]);

        // Masked port gets nothing; enabled it runs; disabling mid-frame does not cut it
        en = 4'b1101;
        add_frame(1, 6, 0);
        repeat (5) begin
            step();
            chk("t4_nogrant", o_grant, 0);
            chk("t4_noready", o_rdy, 0);
        end
        l0 = olog.size();
        en = 4'b1111;
        repeat (3) step();
        en = 4'b1101;
        drain(100);
        chk("t4_beats", olog.size() - l0, 6);
        for (int b = 0; b < 6 && l0 + b < olog.size(); b++) begin
            chk("t4_dest", olog[l0+b].dst, 1);
            chk("t4_last", olog[l0+b].last, b == 5);
        end
        en = '1;

        // 16-beat incrementing frame under random downstream backpressure
        rdy_pct = 50;
        l0 = olog.size();
        add_frame(0, 16, 1);
        drain(400);
        chk("t5_beats", olog.size() - l0, 16);
        for (int b = 0; b < 16 && l0 + b < olog.size(); b++) begin
            chk("t5_data", olog[l0+b].d, b);
            chk("t5_last", olog[l0+b].last, b == 15);
        end
        rdy_pct = 100;

        // Reset mid-frame with rr pointer at 3; afterwards {2,3} must start at port 2
        add_frame(2, 2, 0);
        drain(50);
        add_frame(0, 8, 0);
        repeat (4) step();
        do_reset(1);
        l0 = olog.size();
        add_frame(3, 2, 0); add_frame(2, 2, 0);
        drain(100);
        ed = '{2, 2, 3, 3, 0, 0};
        chk("t6_beats", olog.size() - l0, 4);
        for (int b = 0; b < 4 && l0 + b < olog.size(); b++) chk("t6_dest", olog[l0+b].dst, ed[b]);

        // Random traffic, random masks, random valid gaps and backpressure
        vld_pct = 70; rdy_pct = 60;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, P - 1);
                if (q[p].size() < 12) add_frame(p, $urandom_range(1, 6), 0);
            end
            if (c % 64 == 0) en = P'($urandom());
            step();
        end
        en = '1; vld_pct = 100; rdy_pct = 100;
        drain(3000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
